// File: rtl/apb_rr_master.sv
// Round-robin arbitrating APB master: NUM_REQ requesters share one APB slave port.
// Runs IDLE -> SETUP -> ACCESS per transfer and aborts a hung slave after TIMEOUT ACCESS cycles.
module apb_rr_master #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 16
) (
    input  logic                             pclk,
    input  logic                             preset_n,
    input  logic [NUM_REQ-1:0]               req_valid,
    input  logic [NUM_REQ-1:0]               req_write,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
    output logic [NUM_REQ-1:0]               rsp_valid,
    output logic [DATA_WIDTH-1:0]            rsp_rdata,
    output logic                             rsp_err,
    output logic [ADDR_WIDTH-1:0]            paddr,
    output logic                             pwrite,
    output logic                             psel,
    output logic                             penable,
    output logic [DATA_WIDTH-1:0]            pwdata,
    input  logic                             pready,
    input  logic [DATA_WIDTH-1:0]            prdata,
    input  logic                             pslverr
);

    localparam int IDX_W     = $clog2(NUM_REQ);
    localparam int CNT_W     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int TO_LAST_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TO_LAST_I);
    localparam logic [IDX_W:0]   NREQ_V  = (IDX_W + 1)'(NUM_REQ);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;

    logic [1:0]         state;
    logic [IDX_W-1:0]   ptr;
    logic [CNT_W-1:0]   cnt;
    logic [NUM_REQ-1:0] elig;
    logic               grant;
    logic [IDX_W-1:0]   win;
    logic [IDX_W:0]     cand;
    logic               timed_out;
    logic               done;

    // A requester whose completion pulse is out this cycle has not yet seen it, so mask it.
    assign elig = req_valid & ~rsp_valid;

    always_comb begin
        grant = 1'b0;
        win   = '0;
        cand  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = {1'b0, ptr} + (IDX_W + 1)'(k);
            if (cand >= NREQ_V) cand = cand - NREQ_V;
            if (!grant && elig[cand[IDX_W-1:0]]) begin
                grant = 1'b1;
                win   = cand[IDX_W-1:0];
            end
        end
    end

    assign timed_out = (TIMEOUT != 0) && (cnt == TO_LAST);
    assign done      = pready || timed_out;

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            state     <= ST_IDLE;
            ptr       <= IDX_W'(NUM_REQ - 1);
            cnt       <= '0;
            psel      <= 1'b0;
            penable   <= 1'b0;
            paddr     <= '0;
            pwrite    <= 1'b0;
            pwdata    <= '0;
            rsp_valid <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= '0;
            case (state)
                ST_IDLE: begin
                    if (grant) begin
                        state   <= ST_SETUP;
                        psel    <= 1'b1;
                        penable <= 1'b0;
                        ptr     <= win;
                        paddr   <= req_addr[int'(win)*ADDR_WIDTH +: ADDR_WIDTH];
                        pwdata  <= req_wdata[int'(win)*DATA_WIDTH +: DATA_WIDTH];
                        pwrite  <= req_write[win];
                    end
                end
                ST_SETUP: begin
                    state   <= ST_ACCESS;
                    penable <= 1'b1;
                    cnt     <= '0;
                end
                ST_ACCESS: begin
                    if (done) begin
                        state          <= ST_IDLE;
                        psel           <= 1'b0;
                        penable        <= 1'b0;
                        rsp_valid[ptr] <= 1'b1;
                        // A real pready beats a coincident timeout.
                        if (pready) begin
                            rsp_err   <= pslverr;
                            rsp_rdata <= pwrite ? '0 : prdata;
                        end else begin
                            rsp_err   <= 1'b1;
                            rsp_rdata <= '0;
                        end
                    end else if (TIMEOUT != 0) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_rr_master.sv
// Directed bench for apb_rr_master: latency, wait states, round-robin order,
// slave error, timeout abort and reset during ACCESS.
module tb_apb_rr_master;

    localparam int NUM_REQ = 4;
    localparam int AW      = 32;
    localparam int DW      = 32;
    localparam int TO      = 16;

    logic                  pclk = 1'b0;
    logic                  preset_n;
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_write;
    logic [NUM_REQ*AW-1:0] req_addr;
    logic [NUM_REQ*DW-1:0] req_wdata;
    logic [NUM_REQ-1:0]    rsp_valid;
    logic [DW-1:0]         rsp_rdata;
    logic                  rsp_err;
    logic [AW-1:0]         paddr;
    logic                  pwrite;
    logic                  psel;
    logic                  penable;
    logic [DW-1:0]         pwdata;
    logic                  pready;
    logic [DW-1:0]         prdata;
    logic                  pslverr;

    int n_chk  = 0;
    int n_fail = 0;

    apb_rr_master #(
        .NUM_REQ(NUM_REQ), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)
    ) dut (
        .pclk(pclk), .preset_n(preset_n),
        .req_valid(req_valid), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .paddr(paddr), .pwrite(pwrite), .psel(psel), .penable(penable),
        .pwdata(pwdata), .pready(pready), .prdata(prdata), .pslverr(pslverr)
    );

    always #5 pclk = ~pclk;

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_bus(input string tag, input logic s, input logic e);
        chk({tag, ".psel"}, 32'(psel), 32'(s));
        chk({tag, ".penable"}, 32'(penable), 32'(e));
    endtask

    logic [3:0] rr_order [5];
    logic [3:0] g;

    initial begin
        preset_n  = 1'b0;
        req_valid = '0;
        req_write = '0;
        req_addr  = '0;
        req_wdata = '0;
        pready    = 1'b0;
        prdata    = '0;
        pslverr   = 1'b0;
        req_addr[0*AW +: AW]  = 32'h10;
        req_wdata[0*DW +: DW] = 32'hCAFE;
        req_addr[1*AW +: AW]  = 32'h20;
        req_addr[2*AW +: AW]  = 32'h30;
        req_wdata[2*DW +: DW] = 32'h55;
        req_addr[3*AW +: AW]  = 32'h40;
        req_write[0] = 1'b1;

        tick(); tick();
        chk_bus("reset", 1'b0, 1'b0);
        chk("reset.rsp_valid", 32'(rsp_valid), 32'h0);
        chk("reset.paddr", paddr, 32'h0);
        chk("reset.rsp_err", 32'(rsp_err), 32'h0);
        preset_n = 1'b1;
        tick();

        // 1: req0 write, zero-wait slave
        req_valid[0] = 1'b1;
        pready = 1'b1;
        chk_bus("t1.c0", 1'b0, 1'b0);
        tick();
        chk_bus("t1.c1", 1'b1, 1'b0);
        chk("t1.paddr", paddr, 32'h10);
        chk("t1.pwrite", 32'(pwrite), 32'h1);
        chk("t1.pwdata", pwdata, 32'hCAFE);
        tick();
        chk_bus("t1.c2", 1'b1, 1'b1);
        tick();
        chk_bus("t1.c3", 1'b0, 1'b0);
        chk("t1.rsp_valid", 32'(rsp_valid), 32'h1);
        chk("t1.rsp_err", 32'(rsp_err), 32'h0);
        chk("t1.rsp_rdata", rsp_rdata, 32'h0);
        tick();
        chk_bus("t1.mask", 1'b0, 1'b0);
        chk("t1.pulse_end", 32'(rsp_valid), 32'h0);
        req_valid[0] = 1'b0;
        tick();

        // 2: req1 read, three wait states
        req_valid[1] = 1'b1;
        pready = 1'b0;
        tick();
        chk_bus("t2.c1", 1'b1, 1'b0);
        chk("t2.paddr", paddr, 32'h20);
        chk("t2.pwrite", 32'(pwrite), 32'h0);
        tick(); chk_bus("t2.w1", 1'b1, 1'b1);
        tick(); chk_bus("t2.w2", 1'b1, 1'b1);
        tick(); chk_bus("t2.w3", 1'b1, 1'b1);
        tick(); chk_bus("t2.acc4", 1'b1, 1'b1);
        chk("t2.paddr_stable", paddr, 32'h20);
        pready = 1'b1;
        prdata = 32'h1234;
        tick();
        chk_bus("t2.done", 1'b0, 1'b0);
        chk("t2.rsp_valid", 32'(rsp_valid), 32'h2);
        chk("t2.rsp_rdata", rsp_rdata, 32'h1234);
        chk("t2.rsp_err", 32'(rsp_err), 32'h0);
        req_valid[1] = 1'b0;
        prdata = 32'hDEAD;
        tick();
        chk("t2.rdata_hold", rsp_rdata, 32'h1234);
        chk("t2.paddr_kept", paddr, 32'h20);

        // 5: req2 write with slave error, req3 pending next
        req_write[2] = 1'b1;
        req_valid = 4'b1100;
        pslverr = 1'b1;
        tick();
        chk("t5.paddr", paddr, 32'h30);
        chk("t5.pwrite", 32'(pwrite), 32'h1);
        tick(); chk_bus("t5.c2", 1'b1, 1'b1);
        tick();
        chk("t5.rsp_valid", 32'(rsp_valid), 32'h4);
        chk("t5.rsp_err", 32'(rsp_err), 32'h1);
        chk("t5.rsp_rdata", rsp_rdata, 32'h0);
        req_valid[2] = 1'b0;
        pslverr = 1'b0;
        prdata = 32'h7777;
        tick();
        chk_bus("t5.next", 1'b1, 1'b0);
        chk("t5.next_paddr", paddr, 32'h40);
        tick();
        tick();
        chk("t5.r3_valid", 32'(rsp_valid), 32'h8);
        chk("t5.r3_rdata", rsp_rdata, 32'h7777);
        chk("t5.r3_err", 32'(rsp_err), 32'h0);
        req_valid = '0;
        tick();

        // 3: all requesters held, pointer last on req3
        for (int i = 0; i < NUM_REQ; i++) req_addr[i*AW +: AW] = 32'h100 + 32'(i * 4);
        req_write = '0;
        prdata = 32'hA5;
        req_valid = 4'hF;
        rr_order[0] = 4'd0; rr_order[1] = 4'd1; rr_order[2] = 4'd2;
        rr_order[3] = 4'd3; rr_order[4] = 4'd0;
        for (int n = 0; n < 5; n++) begin
            g = rr_order[n];
            tick();
            chk_bus($sformatf("t3.g%0d.setup", n), 1'b1, 1'b0);
            chk($sformatf("t3.g%0d.paddr", n), paddr, 32'h100 + 32'(g) * 4);
            tick();
            chk_bus($sformatf("t3.g%0d.access", n), 1'b1, 1'b1);
            tick();
            chk_bus($sformatf("t3.g%0d.idle", n), 1'b0, 1'b0);
            chk($sformatf("t3.g%0d.rsp_valid", n), 32'(rsp_valid), 32'h1 << g);
        end
        req_valid = '0;
        tick();
        chk_bus("t3.quiet", 1'b0, 1'b0);

        // 4: hung slave on req2 read
        pready = 1'b0;
        prdata = 32'hBEEF;
        req_valid[2] = 1'b1;
        tick();
        chk_bus("t4.setup", 1'b1, 1'b0);
        for (int c = 0; c < TO; c++) begin
            tick();
            chk_bus($sformatf("t4.acc%0d", c), 1'b1, 1'b1);
        end
        tick();
        chk_bus("t4.abort", 1'b0, 1'b0);
        chk("t4.rsp_valid", 32'(rsp_valid), 32'h4);
        chk("t4.rsp_err", 32'(rsp_err), 32'h1);
        chk("t4.rsp_rdata", rsp_rdata, 32'h0);
        req_valid = '0;
        tick();

        // 6: reset while req3 is in ACCESS; pointer must return to req0-first
        req_valid = 4'b1001;
        tick();
        chk("t6.paddr", paddr, 32'h10C);
        tick();
        chk_bus("t6.access", 1'b1, 1'b1);
        preset_n = 1'b0;
        #1;
        chk_bus("t6.async", 1'b0, 1'b0);
        tick();
        chk("t6.no_rsp", 32'(rsp_valid), 32'h0);
        chk("t6.paddr_rst", paddr, 32'h0);
        preset_n = 1'b1;
        pready = 1'b1;
        tick();
        chk_bus("t6.re_setup", 1'b1, 1'b0);
        chk("t6.re_paddr", paddr, 32'h100);
        tick();
        tick();
        chk("t6.r0_valid", 32'(rsp_valid), 32'h1);
        req_valid[0] = 1'b0;
        tick();
        chk("t6.r3_paddr", paddr, 32'h10C);
        tick();
        tick();
        chk("t6.r3_valid", 32'(rsp_valid), 32'h8);
        req_valid = '0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected end of test");
        $fatal(1, "bench did not finish");
    end

endmodule
